// File: rtl/ram_program_loader_if.sv
// Word handshake from the boot source and byte write port toward the instruction memory.
interface ram_program_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned WORD_W = 4 * DATA_W;

    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic              word_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output word_valid, word_data, word_last,
        input  word_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  word_valid, word_data, word_last,
        output word_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_program_loader.sv
// Splits 32-bit program words into LSB-first byte writes at consecutive addresses.
// Optional running byte checksum output enabled by LOADER_CHECKSUM_EN.
module ram_program_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              abort,
    ram_program_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [7:0]        word_count,
    output logic              wrap_flag
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam int unsigned WORD_W = 4 * DATA_W;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  ptr;
    logic [IDX_W-1:0]   idx;
    logic [WORD_W-1:0]  word_q;
    logic               last_q;
    logic               mem_we_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [DATA_W-1:0]  mem_wdata_r;

    logic               word_ready;
    logic               start_c;
    logic               accept_c;
    logic               write_c;
    logic               finish_c;
    logic               abort_c;
    logic [DATA_W-1:0]  byte_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort outranks any handshake or write progress
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCEPT;
            ACCEPT:  if (abort) state_nxt = IDLE;
                     else if (bus.word_valid) state_nxt = WRITE;
            WRITE:   if (abort) state_nxt = IDLE;
                     else if (idx == IDX_W'(3)) state_nxt = last_q ? DONE : ACCEPT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        word_ready = 1'b0;
        start_c    = 1'b0;
        accept_c   = 1'b0;
        write_c    = 1'b0;
        finish_c   = 1'b0;
        abort_c    = 1'b0;
        byte_c     = word_q[int'(idx) * DATA_W +: DATA_W];
        case (state)
            IDLE:   start_c = start;
            ACCEPT: begin
                word_ready = 1'b1;
                abort_c    = abort;
                accept_c   = bus.word_valid & ~abort;
            end
            WRITE: begin
                abort_c = abort;
                write_c = ~abort;
            end
            DONE: begin
                abort_c  = abort;
                finish_c = ~abort;
            end
            default: ;
        endcase
    end

    // Pointer, byte sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            idx         <= '0;
            word_q      <= '0;
            last_q      <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            word_count  <= '0;
            wrap_flag   <= 1'b0;
        end else begin
            mem_we_r <= write_c;
            done     <= finish_c;
            if (start_c) begin
                ptr        <= base_addr;
                word_count <= '0;
                wrap_flag  <= 1'b0;
                busy       <= 1'b1;
            end
            if (accept_c) begin
                word_q     <= bus.word_data;
                last_q     <= bus.word_last;
                word_count <= word_count + 8'd1;
                idx        <= '0;
            end
            if (write_c) begin
                mem_addr_r  <= ptr;
                mem_wdata_r <= byte_c;
                ptr         <= ptr + ADDR_W'(1);
                idx         <= idx + IDX_W'(1);
                if (ptr == {ADDR_W{1'b1}}) wrap_flag <= 1'b1;
            end
            if (abort_c || finish_c) busy <= 1'b0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of every byte presented to the memory
    always_ff @(posedge clk) begin
        if (rst)          checksum <= '0;
        else if (start_c) checksum <= '0;
        else if (write_c) checksum <= checksum + byte_c;
    end
`endif

    assign bus.word_ready = word_ready;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;

endmodule
